// File: rtl/mem_write_checker.sv
// Store-bus observer: registered PASS/FAIL/TIMEOUT verdict plus a first-word-fall-through trace FIFO.
// Optional macro MEM_WRITE_CHECKER_TIMESTAMP_EN adds a 16-bit push timestamp per entry (trace_time).
module mem_write_checker #(
  parameter int unsigned ADR_W      = 13,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PASS_ADR   = 55,
  parameter int unsigned PASS_DATA  = 1,
  parameter int unsigned IGNORE_ADR = 96,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic [ADR_W-1:0]  data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              pass,
  output logic [1:0]        status,
  output logic [15:0]       store_count,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [ADR_W-1:0]  trace_adr,
  output logic [DATA_W-1:0] trace_data,
  output logic              overflow
`ifdef MEM_WRITE_CHECKER_TIMESTAMP_EN
  ,
  output logic [15:0]       trace_time
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0]  PASS_A = ADR_W'(PASS_ADR);
  localparam logic [ADR_W-1:0]  IGN_A  = ADR_W'(IGNORE_ADR);
  localparam logic [DATA_W-1:0] PASS_D = DATA_W'(PASS_DATA);

  state_t      state;
  logic [31:0] tcnt;

  assign status = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      store_count <= '0;
      tcnt        <= '0;
    end else if (state == ST_RUN) begin
      tcnt <= tcnt + 32'd1;
      if (mem_write) begin
        if (store_count != 16'hFFFF)
          store_count <= store_count + 16'd1;
        if (data_adr == PASS_A && write_data == PASS_D) begin
          state <= ST_PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (data_adr != IGN_A) begin
          state <= ST_FAIL;
          done  <= 1'b1;
        end
      end else if (TIMEOUT != 0 && tcnt == TO_LAST) begin
        state <= ST_TIMEOUT;
        done  <= 1'b1;
      end
    end
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable without a count.
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_idx, rd_idx;
  logic              empty, full, push_req, push, pop;
  logic [ADR_W-1:0]  adr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  assign wr_idx   = wr_ptr[PW-1:0];
  assign rd_idx   = rd_ptr[PW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign push_req = (state == ST_RUN) && mem_write;
  assign pop      = !empty && trace_ready;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (PW+1)'(1);
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  // When full, the write slot is the head being popped on the same edge, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_idx]  <= data_adr;
      data_mem[wr_idx] <= write_data;
    end
  end

  assign trace_valid = !empty;
  assign trace_adr   = empty ? '0 : adr_mem[rd_idx];
  assign trace_data  = empty ? '0 : data_mem[rd_idx];

`ifdef MEM_WRITE_CHECKER_TIMESTAMP_EN
  logic [15:0] cycle_cnt;
  logic [15:0] time_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push)
      time_mem[wr_idx] <= cycle_cnt;
  end

  assign trace_time = empty ? '0 : time_mem[rd_idx];
`endif

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Downstream observer of the processor data-memory write bus on the DE0-Nano top level.
- Samples every store (mem_write, data_adr, write_data) and issues a registered pass/fail/timeout verdict. Convention: PASS on write of PASS_DATA to PASS_ADR; FAIL on any write to an address other than IGNORE_ADR.
- Buffers each sampled store in a small trace FIFO, drained over a valid/ready port (UART or logic-analyser export). Synthesizable replacement for the bench-only checker.

Parameters:
- ADR_W, 13, data address width
- DATA_W, 16, store data width
- DEPTH, 8, trace FIFO entries; power of two, ≥2
- PASS_ADR, 55, completion address
- PASS_DATA, 1, completion value
- IGNORE_ADR, 96, address whose stores are tolerated without verdict
- TIMEOUT, 4096, cycles in RUN before TIMEOUT verdict; 0 disables

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mem_write  in  1  store strobe, one cycle per store
- data_adr  in  ADR_W  store address
- write_data  in  DATA_W  store data
- done  out  1  verdict reached (sticky)
- pass  out  1  verdict is PASS (sticky)
- status  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
- store_count  out  16  stores sampled in RUN, saturating at 0xFFFF
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer accepts head
- trace_adr  out  ADR_W  head address
- trace_data  out  DATA_W  head data
- overflow  out  1  sticky: a store was dropped because FIFO full

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state RUN, status 00, done 0, pass 0, store_count 0, timeout counter 0, FIFO empty, trace_valid 0, trace_adr/trace_data 0, overflow 0.
- Reset mid-operation clears everything, including sticky verdict and FIFO contents, on that edge.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- In RUN, on an edge with mem_write=1, priority order:
  - (a) data_adr==PASS_ADR and write_data==PASS_DATA → PASS.
  - (b) data_adr!=IGNORE_ADR → FAIL.
  - (c) otherwise stay in RUN.
- PASS_ADR with any other data → FAIL.
- Verdict latency: status/done/pass update on the same edge that samples the store, visible in the following cycle.
- Timeout: counter increments every RUN cycle. When TIMEOUT!=0 and the counter equals TIMEOUT-1 with no store on that edge → TIMEOUT. A store on that edge is evaluated normally and takes priority.
- store_count increments on every store sampled in RUN, including the terminating store. Frozen in terminal states.
- FIFO push: every store sampled in RUN, including the terminating one. Stores after the verdict are ignored.
- FIFO pop: trace_valid & trace_ready.
- FIFO presentation: first-word-fall-through; trace_valid rises the cycle after the first push. Head fields hold while trace_valid=1 and trace_ready=0.
- Full + push + pop on the same edge: both occur, no drop.
- Full + push, no pop: store dropped, overflow set. Verdict and store_count still update.
- Empty + pop request: ignored, trace_valid stays 0.
- Empty + push on the same edge: entry visible next cycle.
- Pointers: log2(DEPTH) bits plus a wrap bit. Full/empty derived from pointer compare, no separate counter.
- The FIFO keeps draining in terminal states.

Optional Feature:
- Macro: MEM_WRITE_CHECKER_TIMESTAMP_EN.
- Defined:
  - Free-running 16-bit cycle counter, cleared by reset, wraps 0xFFFF→0.
  - Each FIFO entry also stores the counter value at its push edge.
  - Extra output port trace_time (16 bits), aligned with trace_adr/trace_data.
- Undefined: counter, storage and trace_time port are absent; all other behaviour identical.

Test Plan:
- Reset, stores to 96 (data 5), then 55 (data 1) → status 01, done=1 and pass=1 one cycle after the 55 store; store_count=2; FIFO holds (96,5),(55,1).
- Store to 40 (data 7) → status 10, pass=0; a later store to 55/1 leaves status 10 and store_count=1.
- Store to 55 with data 2 → status 10.
- TIMEOUT=16, no stores → status 11 exactly 16 cycles after reset deasserts. Variant: store to 55/1 on cycle 15 → status 01.
- DEPTH=8, trace_ready=0, nine stores to 96 → trace_valid=1, overflow=1, store_count=9. Then trace_ready=1 → exactly 8 entries drain in order, then trace_valid=0.
- FIFO full with trace_ready=1 while a store arrives → no overflow, count stays at 8. Reset asserted mid-drain → trace_valid=0, status 00 next cycle.
